fifo_collect: RTL and testbench
===============================

// Module: fifo_collect
// PURPOSE
//  Serial-in / parallel-out collector: the read-side counterpart of the parallel-load delay buffers.
//  Accepts a word stream on d, e.g. from one systolic row/column output, one word per accepted beat.
//  Every DEPTH accepted beats it presents the newest OUTPUT_DEPTH words as one parallel frame.
//  The first DEPTH-OUTPUT_DEPTH beats of each frame are skew padding and are dropped.
//  Frame hand-off to the result writer uses a valid/ready handshake with input back-pressure.
// PARAMETERS
//  DEPTH         8   shift-register entries = beats per frame (>=2)
//  BITS          64  word width
//  OUTPUT_DEPTH  8   words per output frame (1..DEPTH)
// PORTS
//  clk        in   1                     clock; single clock domain
//  rst        in   1                     synchronous, active-high reset
//  clr        in   1                     synchronous frame flush (lower priority than rst)
//  in_valid   in   1                     d carries a word this cycle
//  in_ready   out  1                     collector can accept d this cycle
//  d          in   BITS                  stream word
//  out_valid  out  1                     out_array holds a complete frame
//  out_ready  in   1                     consumer takes the frame this cycle
//  out_array  out  BITS x [OUTPUT_DEPTH] frame; [0] = oldest retained word, [OUTPUT_DEPTH-1] = newest
//  fill_cnt   out  $clog2(DEPTH+1)       beats accepted in the current frame
// BEHAVIOUR
//  - Reset (rst=1 at posedge): regs, out_array, fill_cnt = 0; out_valid = 0; state = FILL.
//    Reset mid-frame or in STALL discards all data. in_ready = 1 the cycle after reset.
//  - accept = in_valid & in_ready. On accept, d shifts into regs[DEPTH-1] and entries move toward
//    index 0: regs <= {d, regs[DEPTH-1:1]}. fill_cnt increments.
//  - in_ready = (state == FILL); combinational from state only; never depends on in_valid.
//  - slot_free = ~out_valid | out_ready.
//  - FILL state:
//    - accept with fill_cnt == DEPTH-1 completes the frame.
//    - If slot_free: next cycle out_array[i] = shifted regs[DEPTH-OUTPUT_DEPTH+i], out_valid = 1,
//      fill_cnt = 0, state stays FILL. Latency is 1 cycle from the last beat to out_valid.
//    - Else: state -> STALL, fill_cnt = DEPTH, and regs hold the completed frame.
//  - STALL state: in_ready = 0. When slot_free, load out_array from regs[DEPTH-OUTPUT_DEPTH+i],
//    set out_valid = 1, fill_cnt = 0, state -> FILL.
//  - out_valid & out_ready with no new load in the same cycle: out_valid -> 0 next cycle;
//    out_array keeps its value.
//  - While out_valid & ~out_ready, out_array and out_valid are held stable.
//  - Drain and load in the same cycle: the new frame replaces the old one with no bubble;
//    out_valid stays 1.
//  - Bubbles (in_valid = 0) do not advance regs or fill_cnt; the frame result is independent of gaps.
//  - clr (rst = 0): regs and fill_cnt -> 0, out_valid -> 0, state -> FILL; any pending frame is discarded.
//    clr overrides an accept or load in the same cycle.
//  - fill_cnt never exceeds DEPTH.
// STRUCTURE
//  - Package fifo_pkg: typedef enum logic {FILL, STALL} collect_state_t.
//    Width helper localparam CNT_W = $clog2(DEPTH+1) is also in fifo_pkg.
//  - Sub-module collect_ctrl: FSM, fill_cnt, in_ready, out_valid, load strobe.
//    The parent holds the shift register and the out_array register.
// TESTING (DEPTH=8, OUTPUT_DEPTH=4, BITS=16)
//  1. Hold rst for 2 cycles -> out_valid=0, in_ready=1, fill_cnt=0, out_array all 0.
//  2. Stream 1..8 back-to-back with out_ready=1 -> the cycle after beat 8, out_valid=1 and
//     out_array={5,6,7,8} ([0]=5); the following cycle out_valid=0.
//  3. Hold out_ready=0 and stream 1..16 -> frame {5,6,7,8} held stable; after beat 16,
//     in_ready=0 and fill_cnt=8. Pulse out_ready -> next cycle out_array={13,14,15,16},
//     out_valid=1, in_ready=1.
//  4. Frame A pending; beat 8 of frame B arrives in the same cycle as out_ready=1 -> no STALL;
//     next cycle out_array = frame B and out_valid stays 1.
//  5. Stream 1..5, then clr, then 21..28 -> out_array={25,26,27,28}.
//     Assert rst while in STALL -> all reset values.
//  6. Stream 1..8 with random in_valid gaps -> same {5,6,7,8}; no accept while in_ready=0.

Source files
------------

// File: rtl/fifo_collect_pkg.sv
// Shared types and width helpers for the serial-in / parallel-out collector.
// Imported by the control FSM and the datapath top.
package fifo_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } collect_state_t;

  localparam int DEF_DEPTH = 8;
  localparam int CNT_W     = $clog2(DEF_DEPTH + 1);

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_collect_if.sv
// Stream-in / frame-out handshake bundle for the collector.
// slave is the collector's view, master the producer/consumer's view.
interface fifo_collect_if #(
  parameter int BITS         = 64,
  parameter int OUTPUT_DEPTH = 8
);

  logic                              in_valid;
  logic                              in_ready;
  logic [BITS-1:0]                   d;
  logic                              out_valid;
  logic                              out_ready;
  logic [OUTPUT_DEPTH-1:0][BITS-1:0] out_array;

  modport slave (
    input  in_valid,
    input  d,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_array
  );

  modport master (
    output in_valid,
    output d,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_array
  );

endinterface

// File: rtl/fifo_collect_ctrl.sv
// Collector control: FILL/STALL FSM, beat counter, frame-valid flag
// and the strobe that loads the parallel output frame.
module collect_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic          accept,
  output logic          load,
  output logic [CW-1:0] fill_cnt
);

  collect_state_t state_q, state_d;
  logic [CW-1:0]  fill_cnt_q, fill_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           slot_free;
  logic           load_raw;

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid & in_ready & ~clr;
  assign slot_free = ~out_valid_q | out_ready;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    load_raw   = 1'b0;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          if (fill_cnt_q == CW'(DEPTH - 1)) begin
            if (slot_free) begin
              load_raw   = 1'b1;
              fill_cnt_d = '0;
            end else begin
              state_d    = STALL;
              fill_cnt_d = CW'(DEPTH);
            end
          end else begin
            fill_cnt_d = fill_cnt_q + CW'(1);
          end
        end
      end
      STALL: begin
        if (slot_free) begin
          load_raw   = 1'b1;
          fill_cnt_d = '0;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // a new frame always wins over draining the old one
    out_valid_d = out_valid_q;
    if (load_raw)
      out_valid_d = 1'b1;
    else if (out_valid_q & out_ready)
      out_valid_d = 1'b0;

    if (clr) begin
      state_d     = FILL;
      fill_cnt_d  = '0;
      out_valid_d = 1'b0;
      load_raw    = 1'b0;
    end
  end

  assign load      = load_raw;
  assign out_valid = out_valid_q;
  assign fill_cnt  = fill_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: rtl/fifo_collect.sv
// Serial-in / parallel-out collector: shifts DEPTH beats per frame and
// presents the newest OUTPUT_DEPTH words as one handshaked frame.
module fifo_collect
  import fifo_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int BITS         = 64,
  parameter int OUTPUT_DEPTH = 8,
  localparam int CW          = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  fifo_collect_if.slave bus,
  output logic [CW-1:0] fill_cnt
);

  localparam int SKEW = DEPTH - OUTPUT_DEPTH;

  typedef logic [DEPTH-1:0][BITS-1:0]        regs_t;
  typedef logic [OUTPUT_DEPTH-1:0][BITS-1:0] frame_t;

  regs_t  regs_q, regs_d, shifted, src;
  frame_t out_array_q, out_array_d;
  logic   accept;
  logic   load;

  collect_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .accept    (accept),
    .load      (load),
    .fill_cnt  (fill_cnt)
  );

  assign shifted = {bus.d, regs_q[DEPTH-1:1]};
  // in FILL the frame completes this cycle, in STALL it is parked in regs
  assign src     = accept ? shifted : regs_q;

  always_comb begin
    regs_d = regs_q;
    if (clr)
      regs_d = '0;
    else if (accept)
      regs_d = shifted;
  end

  always_comb begin
    out_array_d = out_array_q;
    if (load) begin
      for (int i = 0; i < OUTPUT_DEPTH; i++)
        out_array_d[i] = src[SKEW + i];
    end
  end

  assign bus.out_array = out_array_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q      <= '0;
      out_array_q <= '0;
    end else begin
      regs_q      <= regs_d;
      out_array_q <= out_array_d;
    end
  end

endmodule

// File: tb/tb_fifo_collect.sv
// Directed bench for fifo_collect at DEPTH=8, OUTPUT_DEPTH=4, BITS=16.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fifo_collect;

  localparam int DEPTH = 8;
  localparam int BITS  = 16;
  localparam int OD    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] fill_cnt;
  int         n_run = 0;
  int         n_fail = 0;

  fifo_collect_if #(.BITS(BITS), .OUTPUT_DEPTH(OD)) bus ();

  fifo_collect #(
    .DEPTH        (DEPTH),
    .BITS         (BITS),
    .OUTPUT_DEPTH (OD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .bus      (bus),
    .fill_cnt (fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame(input int a, input int b,
                                        input int c, input int e);
    return {e[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v);
    bus.in_valid = 1'b1;
    bus.d        = 16'(v);
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int k;
    int cyc;
    rst           = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.d         = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_cnt", 64'(fill_cnt), 64'd0);
    chk("rst_arr", bus.out_array, 64'd0);

    // back-to-back frame with consumer ready
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      beat(i);
      if (i == 7) chk("t2_cnt7", 64'(fill_cnt), 64'd7);
    end
    chk("t2_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_arr", bus.out_array, frame(5, 6, 7, 8));
    chk("t2_cnt0", 64'(fill_cnt), 64'd0);
    step();
    chk("t2_drain", 64'(bus.out_valid), 64'd0);
    chk("t2_hold_arr", bus.out_array, frame(5, 6, 7, 8));

    // back-pressure into STALL
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      beat(i);
      if (i == 12) chk("t3_held", bus.out_array, frame(5, 6, 7, 8));
    end
    chk("t3_ready0", 64'(bus.in_ready), 64'd0);
    chk("t3_cnt8", 64'(fill_cnt), 64'd8);
    chk("t3_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_arr_old", bus.out_array, frame(5, 6, 7, 8));
    beat(99);
    chk("t3_noacc", 64'(fill_cnt), 64'd8);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t3_arr_new", bus.out_array, frame(13, 14, 15, 16));
    chk("t3_valid2", 64'(bus.out_valid), 64'd1);
    chk("t3_ready1", 64'(bus.in_ready), 64'd1);
    chk("t3_cnt0", 64'(fill_cnt), 64'd0);

    // drain and load in the same cycle
    for (int i = 101; i <= 107; i++) beat(i);
    chk("t4_pend", bus.out_array, frame(13, 14, 15, 16));
    bus.out_ready = 1'b1;
    beat(108);
    chk("t4_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_arr", bus.out_array, frame(105, 106, 107, 108));
    chk("t4_ready", 64'(bus.in_ready), 64'd1);
    step();
    chk("t4_drain", 64'(bus.out_valid), 64'd0);

    // clr mid-frame, with an accept in the clr cycle
    for (int i = 1; i <= 5; i++) beat(i);
    clr = 1'b1;
    beat(77);
    clr = 1'b0;
    chk("t5_clr_cnt", 64'(fill_cnt), 64'd0);
    for (int i = 21; i <= 28; i++) beat(i);
    chk("t5_arr", bus.out_array, frame(25, 26, 27, 28));
    chk("t5_valid", 64'(bus.out_valid), 64'd1);

    // reset while in STALL
    bus.out_ready = 1'b0;
    for (int i = 31; i <= 38; i++) beat(i);
    chk("t5_stall", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("t5_rst_cnt", 64'(fill_cnt), 64'd0);
    chk("t5_rst_arr", bus.out_array, 64'd0);

    // random gaps
    bus.out_ready = 1'b1;
    k   = 1;
    cyc = 0;
    while (k <= 8 && cyc < 200) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.d        = 16'(k);
      if (bus.in_valid && bus.in_ready) k++;
      step();
      cyc++;
      if (k <= 8) chk("t6_novalid", 64'(bus.out_valid), 64'd0);
    end
    bus.in_valid = 1'b0;
    chk("t6_done", 64'(k > 8), 64'd1);
    chk("t6_valid", 64'(bus.out_valid), 64'd1);
    chk("t6_arr", bus.out_array, frame(5, 6, 7, 8));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
